sonic_sensor_scheduler: RTL

Round-robin sequencer for N HC-SR04-style ultrasonic rangers sharing one measurement datapath. Fires each sensor's trigger in turn and times the echo pulse width. Converts the width to whole centimetres and publishes one tagged result per sensor, with timeout detection. Sits between the sensor GPIO pins and the distance consumers (obstacle logic / Qsys register bank), replacing free-running alternating trigger generation so that sensors never fire concurrently and cannot cross-talk.

---
 rtl/sonic_sensor_scheduler_if.sv | 12 +
 rtl/sonic_sensor_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sonic_sensor_scheduler_if.sv
// Result bus of the ultrasonic sensor scheduler: one tagged distance per strobe.
interface sonic_sensor_scheduler_if #(
  parameter int DIST_W = 9
);
  logic              dist_valid;
  logic [2:0]        dist_sensor;
  logic [DIST_W-1:0] dist_cm;
  logic              dist_timeout;

  modport master (output dist_valid, dist_sensor, dist_cm, dist_timeout);
  modport slave  (input  dist_valid, dist_sensor, dist_cm, dist_timeout);
endinterface

// File: rtl/sonic_sensor_scheduler.sv
// Round-robin trigger/echo sequencer for HC-SR04-style rangers sharing one timing datapath.
// Optional macro SONIC_MASK_EN adds a sensor_mask input that skips masked-out sensors.
module sonic_sensor_scheduler #(
  parameter int NUM_SENSORS    = 2,
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2900,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int GAP_CYCLES     = 500000,
  parameter int DIST_W         = 9
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
`ifdef SONIC_MASK_EN
  input  logic [NUM_SENSORS-1:0] sensor_mask,
`endif
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   busy,
  sonic_sensor_scheduler_if.master res
);

  localparam int MAX_A   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_A > TRIG_CYCLES) ? MAX_A : TRIG_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int SUB_W   = $clog2(CM_CYCLES + 1);
  localparam logic [DIST_W-1:0] CM_MAX   = {{(DIST_W-1){1'b1}}, 1'b0};
  localparam logic [DIST_W-1:0] CM_ALL   = {DIST_W{1'b1}};
  localparam logic [2:0]        LAST_IDX = 3'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t                 state_r;
  logic [2:0]             idx_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [SUB_W-1:0]       sub_r;
  logic [DIST_W-1:0]      cm_r;
  logic [NUM_SENSORS-1:0] echo_meta_r;
  logic [NUM_SENSORS-1:0] echo_sync_r;
  logic                   echo_prev_r;
  logic [NUM_SENSORS-1:0] trig_r;
  logic                   busy_r;
  logic                   valid_r;
  logic [2:0]             sensor_r;
  logic [DIST_W-1:0]      dist_cm_r;
  logic                   timeout_r;

  logic       echo_cur_s;
  logic       rise_s;
  logic       fall_s;
  logic       limit_s;
  logic [2:0] next_idx_s;
  logic [2:0] start_idx_s;
  logic       mask_any_s;

  function automatic logic [NUM_SENSORS-1:0] onehot(input logic [2:0] i);
    return NUM_SENSORS'(1'b1) << i;
  endfunction

  assign echo_cur_s = |(echo_sync_r & onehot(idx_r));
  assign rise_s     = echo_cur_s & ~echo_prev_r;
  assign fall_s     = ~echo_cur_s & echo_prev_r;
  assign limit_s    = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef SONIC_MASK_EN
  logic [2:0] cand_s;

  assign mask_any_s  = |sensor_mask;
  assign start_idx_s = (|(sensor_mask & onehot(idx_r))) ? idx_r : next_idx_s;

  // Nearest enabled sensor after idx_r; the descending scan lets the closest candidate win.
  always_comb begin
    next_idx_s = idx_r;
    cand_s     = idx_r;
    for (int k = NUM_SENSORS; k >= 1; k--) begin
      cand_s     = 3'((int'(idx_r) + k) % NUM_SENSORS);
      next_idx_s = (|(sensor_mask & onehot(cand_s))) ? cand_s : next_idx_s;
    end
  end
`else
  assign next_idx_s  = (idx_r == LAST_IDX) ? 3'd0 : idx_r + 3'd1;
  assign start_idx_s = idx_r;
  assign mask_any_s  = 1'b1;
`endif

  // Two-flop synchronizer per echo pin plus the previous selected level for edge detection.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      echo_meta_r <= '0;
      echo_sync_r <= '0;
      echo_prev_r <= 1'b0;
    end else begin
      echo_meta_r <= echo;
      echo_sync_r <= echo_meta_r;
      echo_prev_r <= echo_cur_s;
    end
  end

  // Measurement sequencer with registered trigger, busy and result outputs.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      idx_r     <= 3'd0;
      cnt_r     <= '0;
      sub_r     <= '0;
      cm_r      <= '0;
      trig_r    <= '0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      sensor_r  <= 3'd0;
      dist_cm_r <= '0;
      timeout_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable && mask_any_s) begin
            state_r <= TRIG;
            idx_r   <= start_idx_s;
            trig_r  <= onehot(start_idx_s);
            busy_r  <= 1'b1;
            cnt_r   <= '0;
          end
        end
        TRIG: begin
          if (cnt_r == CNT_W'(TRIG_CYCLES - 1)) begin
            trig_r  <= '0;
            state_r <= WAIT_RISE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WAIT_RISE: begin
          if (rise_s) begin
            state_r <= MEASURE;
            cnt_r   <= '0;
            // The rise cycle itself is the first echo-high clock.
            sub_r   <= SUB_W'(1);
            cm_r    <= '0;
          end else if (limit_s) begin
            state_r   <= GAP;
            cnt_r     <= '0;
            valid_r   <= 1'b1;
            sensor_r  <= idx_r;
            dist_cm_r <= CM_ALL;
            timeout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        MEASURE: begin
          if (fall_s) begin
            state_r   <= GAP;
            cnt_r     <= '0;
            valid_r   <= 1'b1;
            sensor_r  <= idx_r;
            dist_cm_r <= cm_r;
            timeout_r <= 1'b0;
          end else if (limit_s) begin
            state_r   <= GAP;
            cnt_r     <= '0;
            valid_r   <= 1'b1;
            sensor_r  <= idx_r;
            dist_cm_r <= CM_ALL;
            timeout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (sub_r == SUB_W'(CM_CYCLES - 1)) begin
              sub_r <= '0;
              cm_r  <= (cm_r == CM_MAX) ? cm_r : cm_r + DIST_W'(1'b1);
            end else begin
              sub_r <= sub_r + SUB_W'(1);
            end
          end
        end
        GAP: begin
          if (cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
            idx_r <= next_idx_s;
            cnt_r <= '0;
            if (enable && mask_any_s) begin
              state_r <= TRIG;
              trig_r  <= onehot(next_idx_s);
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          trig_r  <= '0;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign trig             = trig_r;
  assign busy             = busy_r;
  assign res.dist_valid   = valid_r;
  assign res.dist_sensor  = sensor_r;
  assign res.dist_cm      = dist_cm_r;
  assign res.dist_timeout = timeout_r;

endmodule
